seven_seg_scanner: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display. Owns the digit

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seven_seg_scanner.sv | 142 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scanner.
package seven_seg_pkg;

  localparam int         DIGIT_W = 5;        // {dp, hex[3:0]}
  localparam logic [6:0] SEG_OFF = 7'h7F;    // all segments dark (active-low)

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h27;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module seg7_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; no state.
  always_comb begin
    seg_o = hex_to_seg(hex_i);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment driver with double-buffered
// digit data, per-digit blanking, leading-zero suppression and PWM brightness.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_suppress,
  input  logic [BRIGHT_BITS-1:0]        brightness,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  // Wide enough to hold 2^BRIGHT_BITS * SCAN_DIV before the shift.
  localparam int ON_W  = BRIGHT_BITS + PRE_W + 1;

  logic [PRE_W-1:0]              pre_q, pre_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] stage_q, stage_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] active_q, active_d;
  logic                          pend_q, pend_d;
  logic [6:0]                    seg_q, seg_d;
  logic                          dp_q, dp_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;
  logic                          fd_q, fd_d;

  logic                          slot_end;
  logic                          boundary;
  logic [ON_W-1:0]               on_cnt;
  logic                          pwm_on;
  logic [DIGIT_W-1:0]            cur_digit;
  logic                          cur_blank;
  logic                          cur_sup;
  logic                          zero_run;
  logic                          dark;
  logic [6:0]                    dec_seg;

  assign slot_end = (pre_q == PRE_W'(SCAN_DIV - 1));
  assign boundary = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

  assign on_cnt = ((ON_W'(brightness) + ON_W'(1)) * ON_W'(SCAN_DIV)) >> BRIGHT_BITS;
  assign pwm_on = (ON_W'(pre_q) < on_cnt);

  // Scan counters and double-buffer next state.
  always_comb begin
    pre_d    = slot_end ? '0 : pre_q + PRE_W'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    // Active always takes the staging value from before this cycle's load,
    // so a load on the boundary waits one full frame.
    active_d = (boundary && pend_q) ? stage_q : active_q;
    stage_d  = load ? digits_in : stage_q;
    pend_d   = load | (pend_q & ~boundary);
  end

  // Select the scanned digit and work out whether it is a suppressed leading zero.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_q[i*DIGIT_W +: DIGIT_W] == '0);
      if (idx_q == IDX_W'(i)) begin
        cur_digit = active_q[i*DIGIT_W +: DIGIT_W];
        cur_blank = blank_mask[i];
        cur_sup   = (i != 0) && zero_run;
      end
    end
  end

  seg7_hex_decode u_dec (
    .hex_i (cur_digit[3:0]),
    .seg_o (dec_seg)
  );

  // Output next state: dark digit drives everything inactive.
  always_comb begin
    dark = cur_blank | (lz_suppress & cur_sup) | ~pwm_on;
    if (dark) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = '1;
    end else begin
      seg_d = dec_seg;
      dp_d  = ~cur_digit[4];
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
    fd_d = boundary;
  end

  // Scan position and digit buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      stage_q  <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      stage_q  <= stage_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= '1;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fd_q  <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_BITS=2).
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BB = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [19:0]   digits_in;
  logic          load;
  logic [3:0]    blank_mask;
  logic          lz_suppress;
  logic [1:0]    brightness;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_BITS(BB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .load        (load),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  // Reference model: scan position derived from cycles elapsed since reset release.
  int          m_n;
  logic [19:0] m_stage;
  logic [19:0] m_active;
  bit          m_pend;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; } slot_t;
  typedef struct { logic [1:0] br; int on; } br_t;
  typedef struct { logic [19:0] din; logic lz; logic [3:0] blank; logic [3:0] mask; } lz_t;

  slot_t scan_tbl [4];
  br_t   br_tbl   [4];
  lz_t   lz_tbl   [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: predict outputs from model state and live inputs, advance model, compare.
  task automatic step();
    int          pres, idx, on;
    logic        lit;
    logic [4:0]  d;
    logic [3:0]  an_e;
    logic [12:0] e;
    pres = m_n % SD;
    idx  = (m_n / SD) % ND;
    on   = ((int'(brightness) + 1) * SD) / (1 << BB);
    d    = m_active[5*idx +: 5];
    lit  = (pres < on) && !blank_mask[idx] &&
           !(lz_suppress && idx >= 1 && (m_active >> (5*idx)) == 20'h0);
    an_e = 4'hF & ~(4'b0001 << idx);
    if (lit) e = {an_e, SEG_TBL[d[3:0]], ~d[4], 1'b0};
    else     e = {4'hF, 7'h7F, 1'b1, 1'b0};
    e[0] = (pres == SD - 1) && (idx == ND - 1);
    if (pres == SD - 1 && idx == ND - 1 && m_pend) begin
      m_active = m_stage;
      m_pend   = 1'b0;
    end
    if (load) begin
      m_stage = digits_in;
      m_pend  = 1'b1;
    end
    m_n++;
    @(posedge clk);
    #1;
    chk("scan_out", {19'h0, an, seg, dp, frame_done}, {19'h0, e});
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk("reset_dark", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    m_n = 0; m_stage = '0; m_active = '0; m_pend = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic align(input int modv, input int target);
    for (int i = 0; i < 2 * FRAME && (m_n % modv) != target; i++) step();
    chk("align", m_n % modv, target);
  endtask

  task automatic do_load(input logic [19:0] v);
    digits_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cnt;
    logic [3:0] mask;

    scan_tbl = '{'{4'b1110, 7'h40, 1'b1}, '{4'b1101, 7'h12, 1'b1},
                 '{4'b1011, 7'h08, 1'b1}, '{4'b0111, 7'h0E, 1'b0}};
    br_tbl   = '{'{2'd0, 2}, '{2'd1, 4}, '{2'd2, 6}, '{2'd3, 8}};
    lz_tbl   = '{'{20'h000E0, 1'b1, 4'b0000, 4'b0011},
                 '{20'h00000, 1'b1, 4'b0000, 4'b0001},
                 '{20'h00000, 1'b0, 4'b0001, 4'b1110},
                 '{20'h000E0, 1'b0, 4'b0000, 4'b1111},
                 '{20'h04000, 1'b1, 4'b0000, 4'b0111},
                 '{20'h000E0, 1'b1, 4'b0001, 4'b0010}};

    rst_n = 1'b1; load = 1'b0; digits_in = '0; blank_mask = '0;
    lz_suppress = 1'b0; brightness = 2'd3;
    #2;

    // Reset and first lit slot, frame_done period.
    apply_reset(3);
    step();
    chk("first_lit_an", {28'h0, an}, 32'hE);
    cnt = 0;
    for (int k = 2; k <= 2 * FRAME; k++) begin
      step();
      if (frame_done) begin
        cnt++;
        chk("fd_period", k % FRAME, 0);
      end
    end
    chk("fd_count", cnt, 2);

    // Scan/decode table after the load lands on a boundary.
    do_load({5'h1F, 5'h0A, 5'h05, 5'h00});
    align(FRAME, 0);
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk("scan_tbl", {an, seg, dp}, {scan_tbl[k/SD].an, scan_tbl[k/SD].seg, scan_tbl[k/SD].dp});
    end

    // Tear-free: A mid-frame, B on the boundary cycle.
    align(FRAME, 10);
    do_load({5'h01, 5'h02, 5'h03, 5'h04});
    align(FRAME, FRAME - 1);
    do_load({5'h05, 5'h06, 5'h07, 5'h09});
    step();
    chk("tear_A_d0", {25'h0, seg}, 32'h19);
    align(FRAME, FRAME - SD);
    step();
    chk("tear_A_d3", {25'h0, seg}, 32'h79);
    align(FRAME, 0);
    step();
    chk("tear_B_d0", {25'h0, seg}, 32'h10);
    align(FRAME, FRAME - SD);
    step();
    chk("tear_B_d3", {25'h0, seg}, 32'h12);

    // Brightness: anode-low cycles per slot.
    for (int t = 0; t < 4; t++) begin
      brightness = br_tbl[t].br;
      align(SD, 0);
      cnt = 0;
      repeat (SD) begin
        step();
        if (an != 4'hF) cnt++;
      end
      chk("bright_on", cnt, br_tbl[t].on);
    end
    brightness = 2'd3;

    // Leading-zero suppression and blanking: digits lit over one frame.
    for (int t = 0; t < 6; t++) begin
      do_load(lz_tbl[t].din);
      lz_suppress = lz_tbl[t].lz;
      blank_mask  = lz_tbl[t].blank;
      align(FRAME, 0);
      mask = 4'h0;
      repeat (FRAME) begin
        step();
        mask = mask | ~an;
      end
      chk("lz_mask", {28'h0, mask}, {28'h0, lz_tbl[t].mask});
    end
    lz_suppress = 1'b0;
    blank_mask  = '0;

    // Reset mid-frame with a pending load.
    do_load({5'h0C, 5'h0D, 5'h0E, 5'h0F});
    align(FRAME, 0);
    do_load({5'h08, 5'h08, 5'h08, 5'h08});
    align(FRAME, 2 * SD + 5);
    apply_reset(2);
    step();
    chk("rst_first_an", {28'h0, an}, 32'hE);
    chk("rst_data_zero", {25'h0, seg}, 32'h40);
    repeat (2 * FRAME) step();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      load        = ($urandom_range(0, 15) == 0);
      digits_in   = 20'($urandom);
      if ($urandom_range(0, 3) == 0) digits_in = digits_in & 20'h000FF;
      brightness  = 2'($urandom);
      blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_suppress = 1'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        load = 1'b0;
        apply_reset(1);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
